// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite transfer, response and read-slave state types
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } ahb_rd_state_t;

endpackage

// File: rtl/ahb_rd_decode.sv
// rtl/ahb_rd_decode.sv - register index extraction and error check for one address phase
module ahb_rd_decode #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 8
) (
  input  logic [ADDR_W-1:0]                    haddr_i,
  input  logic [2:0]                           hsize_i,
  input  logic                                 hwrite_i,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]   idx_o,
  output logic                                 err_o
);

  localparam int BL = $clog2(DATA_W/8);

  logic misalign;

  always_comb begin
    idx_o    = haddr_i[ADDR_W-1:BL];
    misalign = 1'b0;
    // Any set address bit below the transfer size breaks natural alignment.
    for (int i = 0; i < ADDR_W; i++) begin
      if (i < int'(hsize_i) && haddr_i[i]) begin
        misalign = 1'b1;
      end
    end
    err_o = hwrite_i
         || (32'(idx_o) >= NUM_REGS)
         || (hsize_i > 3'(BL))
         || misalign;
  end

endmodule

// File: rtl/ahb_read_regs.sv
// rtl/ahb_read_regs.sv - AHB-Lite read-only register bank slave with wait states,
// two-cycle ERROR response and per-register read strobes.
module ahb_read_regs
  import ahb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                         hclk,
  input  logic                         hreset_n,
  input  logic                         hsel_x,
  input  logic [1:0]                   htrans,
  input  logic [ADDR_W-1:0]            haddr,
  input  logic [2:0]                   hsize,
  input  logic                         hwrite,
  input  logic                         hready,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_data,
  output logic [DATA_W-1:0]            hrdata,
  output logic                         hready_out,
  output logic                         hresp,
  output logic [NUM_REGS-1:0]          rd_strobe
);

  localparam int BL    = $clog2(DATA_W/8);
  localparam int IDX_W = ADDR_W - BL;

  logic [IDX_W-1:0]    dec_idx;
  logic                dec_err;
  htrans_t             trans;
  logic                accept;

  ahb_rd_state_t       state_q;
  logic [3:0]          cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   hrdata_q;
  logic                hready_q;
  logic                hresp_q;
  logic [NUM_REGS-1:0] rd_strobe_q;

  logic [IDX_W-1:0]    rd_idx_d;
  logic [DATA_W-1:0]   hrdata_d;
  logic [NUM_REGS-1:0] rd_strobe_d;

  ahb_rd_decode #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_decode (
    .haddr_i  (haddr),
    .hsize_i  (hsize),
    .hwrite_i (hwrite),
    .idx_o    (dec_idx),
    .err_o    (dec_err)
  );

  assign trans  = htrans_t'(htrans);
  assign accept = hsel_x && hready && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);

  // A waited read keeps its captured index; a zero-wait read uses the live address phase.
  assign rd_idx_d = (state_q == ST_WAIT) ? idx_q : dec_idx;

  always_comb begin
    hrdata_d    = '0;
    rd_strobe_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx_d == IDX_W'(i)) begin
        hrdata_d       = reg_data[i*DATA_W +: DATA_W];
        rd_strobe_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      hrdata_q    <= '0;
      hready_q    <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      rd_strobe_q <= '0;
    end else begin
      rd_strobe_q <= '0;
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q     <= ST_DONE;
            hrdata_q    <= hrdata_d;
            rd_strobe_q <= rd_strobe_d;
            hready_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ERR1: begin
          state_q  <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_ERROR;
        end
        default: begin
          // IDLE, DONE and ERR2 all complete the bus cycle, so a new phase may start here.
          if (accept && dec_err) begin
            state_q  <= ST_ERR1;
            hready_q <= 1'b0;
            hresp_q  <= HRESP_ERROR;
          end else if (accept && WAIT_STATES > 0) begin
            state_q  <= ST_WAIT;
            cnt_q    <= 4'(WAIT_STATES);
            idx_q    <= dec_idx;
            hready_q <= 1'b0;
            hresp_q  <= HRESP_OKAY;
          end else if (accept) begin
            state_q     <= ST_DONE;
            hrdata_q    <= hrdata_d;
            rd_strobe_q <= rd_strobe_d;
            hready_q    <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end else begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign hrdata     = hrdata_q;
  assign hready_out = hready_q;
  assign hresp      = hresp_q;
  assign rd_strobe  = rd_strobe_q;

endmodule

// File: tb/tb_ahb_read_regs.sv
// tb/tb_ahb_read_regs.sv - scoreboard bench for ahb_read_regs, one zero-wait and one
// two-wait instance driven in turn.
module tb_ahb_read_regs;

  typedef struct {
    int acc;
    int due;
    bit err;
    int idx;
  } exp_t;

  logic         hclk = 1'b0;
  logic         hreset_n;
  logic [255:0] reg_data;
  logic         hsel_x     [2];
  logic [1:0]   htrans     [2];
  logic [7:0]   haddr      [2];
  logic [2:0]   hsize      [2];
  logic         hwrite     [2];
  logic         hready     [2];
  logic [31:0]  hrdata     [2];
  logic         hready_out [2];
  logic         hresp      [2];
  logic [7:0]   rd_strobe  [2];

  exp_t         sb [2][$];
  logic [31:0]  exp_rd [2];
  logic [255:0] snap;
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  bit           rand_regs = 0;

  always #5 hclk = ~hclk;

  assign hready[0] = hready_out[0];
  assign hready[1] = hready_out[1];

  ahb_read_regs #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel_x(hsel_x[0]), .htrans(htrans[0]),
    .haddr(haddr[0]), .hsize(hsize[0]), .hwrite(hwrite[0]), .hready(hready[0]),
    .reg_data(reg_data), .hrdata(hrdata[0]), .hready_out(hready_out[0]),
    .hresp(hresp[0]), .rd_strobe(rd_strobe[0])
  );

  ahb_read_regs #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(8), .WAIT_STATES(2)) u_dut1 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel_x(hsel_x[1]), .htrans(htrans[1]),
    .haddr(haddr[1]), .hsize(hsize[1]), .hwrite(hwrite[1]), .hready(hready[1]),
    .reg_data(reg_data), .hrdata(hrdata[1]), .hready_out(hready_out[1]),
    .hresp(hresp[1]), .rd_strobe(rd_strobe[1])
  );

  function automatic int ws(input int k);
    return (k == 1) ? 2 : 0;
  endfunction

  task automatic chk(input int k, input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, k, cyc, act, req);
    end
  endtask

  // Reset abandons every outstanding transfer and clears the read data.
  always @(posedge hclk) begin
    cyc = cyc + 1;
    if (!hreset_n) begin
      sb[0].delete();
      sb[1].delete();
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end
  end

  task automatic mon(input int k);
    exp_t h;
    bit act;
    logic [7:0] es;
    act = 0;
    es  = '0;
    if (sb[k].size() > 0) begin
      h = sb[k][0];
      if (cyc > h.acc) begin
        act = 1;
        if (cyc < h.due) begin
          chk(k, "stall_hready", hready_out[k], 0);
          chk(k, "stall_hresp", hresp[k], h.err);
          chk(k, "stall_strobe", rd_strobe[k], 0);
          chk(k, "stall_hrdata", hrdata[k], exp_rd[k]);
        end else begin
          if (!h.err) begin
            exp_rd[k] = snap[h.idx*32 +: 32];
            es = 8'(1 << h.idx);
          end
          chk(k, "done_hready", hready_out[k], 1);
          chk(k, "done_hresp", hresp[k], h.err);
          chk(k, "done_strobe", rd_strobe[k], es);
          chk(k, "done_hrdata", hrdata[k], exp_rd[k]);
          void'(sb[k].pop_front());
        end
      end
    end
    if (!act) begin
      chk(k, "idle_hready", hready_out[k], 1);
      chk(k, "idle_hresp", hresp[k], 0);
      chk(k, "idle_strobe", rd_strobe[k], 0);
      chk(k, "idle_hrdata", hrdata[k], exp_rd[k]);
    end
  endtask

  // snap holds the register contents as seen at the most recent rising edge.
  always @(negedge hclk) begin
    for (int k = 0; k < 2; k++) mon(k);
    snap = reg_data;
  end

  initial begin
    forever begin
      @(posedge hclk);
      #1;
      if (rand_regs) begin
        for (int i = 0; i < 8; i++) reg_data[i*32 +: 32] = $urandom;
      end
    end
  end

  task automatic quiet(input int k);
    hsel_x[k] = 1'b0;
    htrans[k] = 2'd0;
    haddr[k]  = '0;
    hsize[k]  = 3'd2;
    hwrite[k] = 1'b0;
  endtask

  task automatic idle(input int k, input int n);
    for (int c = 0; c < n; c++) begin
      hsel_x[k] = 1'($urandom);
      htrans[k] = hsel_x[k] ? 2'($urandom_range(0, 1)) : 2'($urandom);
      haddr[k]  = 8'($urandom);
      hwrite[k] = 1'($urandom);
      @(posedge hclk);
      #1;
    end
  endtask

  task automatic xfer(input int k, input logic [7:0] a, input logic [2:0] sz,
                      input logic wr, input logic [1:0] tr);
    exp_t e;
    bit done;
    hsel_x[k] = 1'b1;
    htrans[k] = tr;
    haddr[k]  = a;
    hsize[k]  = sz;
    hwrite[k] = wr;
    done = 0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge hclk);
      if (hready_out[k] === 1'b1 && hreset_n === 1'b1) begin
        e.acc = cyc;
        e.err = wr || ((int'(a) >> 2) >= 8) || (int'(sz) > 2) || ((int'(a) % (1 << sz)) != 0);
        e.due = e.err ? cyc + 2 : cyc + 1 + ws(k);
        e.idx = int'(a) >> 2;
        sb[k].push_back(e);
        done = 1;
      end
      @(posedge hclk);
      #1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL xfer_accept dut%0d cyc=%0d actual=not_accepted required=accepted", k, cyc);
    end
  endtask

  initial begin
    logic [7:0] a;
    logic [2:0] sz;
    bit drained;
    hreset_n  = 1'b0;
    reg_data  = '0;
    snap      = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    quiet(0);
    quiet(1);
    repeat (2) @(posedge hclk);
    #1;
    hreset_n = 1'b1;

    reg_data[3*32 +: 32] = 32'hDEADBEEF;
    xfer(0, 8'h0C, 3'd2, 1'b0, 2'd2);
    quiet(0);
    idle(0, 2);

    reg_data[0*32 +: 32] = 32'h1111_0000;
    reg_data[1*32 +: 32] = 32'h2222_0001;
    reg_data[2*32 +: 32] = 32'h3333_0002;
    xfer(0, 8'h00, 3'd2, 1'b0, 2'd2);
    xfer(0, 8'h04, 3'd2, 1'b0, 2'd3);
    xfer(0, 8'h08, 3'd2, 1'b0, 2'd3);
    quiet(0);
    idle(0, 2);

    xfer(0, 8'h20, 3'd2, 1'b0, 2'd2);
    quiet(0);
    idle(0, 1);
    xfer(0, 8'h00, 3'd2, 1'b1, 2'd2);
    xfer(0, 8'h02, 3'd2, 1'b0, 2'd2);
    xfer(0, 8'h00, 3'd3, 1'b0, 2'd2);
    quiet(0);
    idle(0, 3);

    rand_regs = 1;
    xfer(1, 8'h04, 3'd2, 1'b0, 2'd2);
    quiet(1);
    idle(1, 4);
    xfer(1, 8'h20, 3'd2, 1'b0, 2'd2);
    xfer(1, 8'h00, 3'd2, 1'b1, 2'd2);
    xfer(1, 8'h1C, 3'd1, 1'b0, 2'd2);
    quiet(1);
    idle(1, 4);

    xfer(1, 8'h08, 3'd2, 1'b0, 2'd2);
    quiet(1);
    hreset_n = 1'b0;
    @(posedge hclk);
    #1;
    hreset_n = 1'b1;
    idle(1, 4);

    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 150; t++) begin
        if ($urandom_range(0, 9) < 2) begin
          quiet(k);
          idle(k, $urandom_range(1, 3));
        end else begin
          sz = ($urandom_range(0, 5) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
          a  = 8'($urandom_range(0, 9) * 4);
          if ($urandom_range(0, 3) == 0) a = a + 8'($urandom_range(1, 3));
          xfer(k, a, sz, ($urandom_range(0, 9) == 0), 2'($urandom_range(2, 3)));
        end
      end
      quiet(k);
      idle(k, 3);
    end

    quiet(0);
    quiet(1);
    drained = 0;
    for (int c = 0; c < 20 && !drained; c++) begin
      @(posedge hclk);
      #1;
      drained = (sb[0].size() == 0) && (sb[1].size() == 0);
    end
    if (!drained) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain cyc=%0d actual=%0d/%0d required=0/0", cyc, sb[0].size(), sb[1].size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_read_regs.md
# ahb_read_regs

Parametrised AHB-Lite read-only slave that exposes a bank of `NUM_REGS` status/payload registers of `DATA_W` bits to the bus. It implements the full address/data-phase pipeline, a programmable number of wait states, the two-cycle ERROR response, and a per-register read strobe. It replaces fixed 8-bit, 4-entry read muxing in the AHB subsystem and sits behind the AHB decoder, one instance per peripheral status block.

## Interface
Parameters:
- `DATA_W`, 32, register/bus data width; 8, 16, 32 or 64.
- `NUM_REGS`, 8, number of readable registers; ≥1.
- `ADDR_W`, 8, haddr bits decoded by this slave.
- `WAIT_STATES`, 0, wait cycles inserted in every OKAY data phase; 0–15.

Ports (one clock; reset is synchronous and active-low):
- `hclk` in 1: bus clock, all logic on rising edge.
- `hreset_n` in 1: synchronous active-low reset.
- `hsel_x` in 1: slave select from decoder.
- `htrans` in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `haddr` in ADDR_W: byte address.
- `hsize` in 3: transfer size, log2 bytes.
- `hwrite` in 1: write request; always errored.
- `hready` in 1: bus-level ready, previous transfer complete.
- `reg_data` in NUM_REGS*DATA_W: register contents, reg i at bits [i*DATA_W +: DATA_W].
- `hrdata` out DATA_W: read data.
- `hready_out` out 1: slave ready.
- `hresp` out 1: 0=OKAY, 1=ERROR.
- `rd_strobe` out NUM_REGS: one-hot pulse marking a completed OKAY read of reg i.

## Operation
- Address phase is accepted when `hreset_n && hsel_x && hready && htrans[1]`. Otherwise no transfer; IDLE/BUSY get a zero-wait OKAY.
- Register index is `haddr[ADDR_W-1:BL]`, where BL = log2(DATA_W/8).
- An accepted transfer errors if any of these hold:
  - `hwrite=1`;
  - index ≥ NUM_REGS;
  - hsize > BL;
  - haddr not aligned to 2^hsize.
- FSM states:
  - IDLE: hready_out=1, hresp=0.
  - WAIT: hready_out=0, hresp=0; counter loaded with WAIT_STATES, decrements per cycle.
  - DONE: hready_out=1, hresp=0; hrdata valid.
  - ERR1: hready_out=0, hresp=1.
  - ERR2: hready_out=1, hresp=1.
- FSM transitions:
  - Accepted OKAY → WAIT if WAIT_STATES>0, else DONE.
  - WAIT → DONE when counter reaches 1.
  - Accepted error → ERR1 → ERR2.
  - DONE or ERR2: a new accepted address phase (pipelined) starts the next transfer directly; otherwise → IDLE.
- hrdata is registered. It is loaded from `reg_data[index]` on the edge entering DONE, so it reflects register contents at the end of the last wait cycle. It holds its value outside DONE. Full word is driven; narrow transfers use AHB byte lanes.
- rd_strobe[index] is high exactly in the DONE cycle, and is zero otherwise, including for errors.
- Reset: hrdata=0, hready_out=1, hresp=0, rd_strobe=0, FSM=IDLE. A reset mid-transfer abandons it with no strobe.
- Address phases presented while hready=0 (e.g. during ERR1) are ignored.

## Timing
- OKAY read: address in cycle N; data/hready_out=1 in cycle N+1+WAIT_STATES.
- ERROR: ERR1 in N+1, ERR2 in N+2, independent of WAIT_STATES.
- Back-to-back NONSEQ/SEQ with WAIT_STATES=0: one read completes per cycle, no bubbles.
- hsel_x deasserted during a data phase does not abort it; the data phase completes normally.

## Structure
- Shared `ahb_pkg`:
  - `htrans_t` enum;
  - HRESP_OKAY/HRESP_ERROR constants;
  - `ahb_rd_state_t` enum (IDLE, WAIT, DONE, ERR1, ERR2).
- One sub-module, `ahb_rd_decode`: combinational index extraction and error check (range, size, alignment, write).

## Test plan
- DATA_W=32, NUM_REGS=8, WAIT_STATES=0; reg3=0xDEADBEEF; NONSEQ read haddr=0x0C → hrdata=0xDEADBEEF, hready_out=1, hresp=0 in cycle N+1; rd_strobe=8'b0000_1000 for one cycle.
- WAIT_STATES=2, read haddr=0x04 → hready_out low in N+1 and N+2, data in N+3; reg1 changed at N+2 is the value returned.
- Read haddr=0x20 (index 8) → N+1: hready_out=0, hresp=1; N+2: hready_out=1, hresp=1; rd_strobe stays 0.
- Write to 0x00, then hsize=2 at haddr=0x02, then hsize=3 at 0x00 → each gets the two-cycle ERROR response.
- Back-to-back SEQ reads 0x00, 0x04, 0x08 with WAIT_STATES=0 → hrdata = reg0, reg1, reg2 in consecutive cycles; hready_out stays 1.
- Assert hreset_n=0 during a WAIT cycle → next cycle hready_out=1, hresp=0, hrdata=0, no strobe.
